// File: rtl/scaled_pixel_fetch.sv
// scaled_pixel_fetch
// Maps the display raster onto an integer-upscaled framebuffer. For each
// raster position it computes the framebuffer read address, waits out the
// BRAM read latency and presents the fetched pixel. The syncs, the active
// flag and an end-of-frame pulse arrive in the same cycle as that pixel.
//
// Build option: define SCALE_MIRROR_EN to mirror the framebuffer
// horizontally (selfie view). Latency and reset behaviour are the same in
// both builds.
//
// Ports:
//   clk_pixel_in      pixel clock, all logic on its rising edge
//   rst_in            asynchronous, active-high reset
//   hcount_in         raster column from the timing generator (11 bits)
//   vcount_in         raster line from the timing generator (10 bits)
//   hsync_in          timing-generator hsync
//   vsync_in          timing-generator vsync
//   active_draw_in    timing-generator active-video flag
//   bram_addr_out     framebuffer read address (ADDR_W bits)
//   bram_data_in      framebuffer read data, READ_LATENCY cycles after address
//   scaled_pixel_out  pixel to the colour mux ([7:6] type, [5:0] payload)
//   hsync_out         hsync_in delayed to align with scaled_pixel_out
//   vsync_out         vsync_in delayed to align with scaled_pixel_out
//   active_draw_out   active_draw_in delayed to align with scaled_pixel_out
//   frame_done_out    one-cycle pulse with the output of the last active position
module scaled_pixel_fetch #(
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 720,
    parameter int SCALE_SHIFT  = 2,
    parameter int FB_WIDTH     = 320,
    parameter int FB_HEIGHT    = 180,
    parameter int ADDR_W       = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk_pixel_in,
    input  logic              rst_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              active_draw_in,
    output logic [ADDR_W-1:0] bram_addr_out,
    input  logic [7:0]        bram_data_in,
    output logic [7:0]        scaled_pixel_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              active_draw_out,
    output logic              frame_done_out
);

    logic [10:0]       w_col;
    logic [9:0]        w_row;
    logic              w_in_region;
    logic              w_last_pos;
    logic [ADDR_W-1:0] w_col_eff;
    logic [ADDR_W-1:0] w_addr;

    // Stage 0: registered address and tags
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_active;
    logic              r_last;

    // Delay line covering the BRAM read latency; index READ_LATENCY-1 is
    // the copy that lines up with bram_data_in.
    logic [READ_LATENCY-1:0] r_dl_valid;
    logic [READ_LATENCY-1:0] r_dl_hsync;
    logic [READ_LATENCY-1:0] r_dl_vsync;
    logic [READ_LATENCY-1:0] r_dl_active;
    logic [READ_LATENCY-1:0] r_dl_last;

    assign w_col = hcount_in >> SCALE_SHIFT;
    assign w_row = vcount_in >> SCALE_SHIFT;

    assign w_in_region = active_draw_in
                         && (32'(w_col) < 32'(FB_WIDTH))
                         && (32'(w_row) < 32'(FB_HEIGHT));

    // The frame-end marker depends only on the raster position, so it fires
    // even when the last position is blanked or outside the framebuffer.
    assign w_last_pos = (32'(hcount_in) == 32'(H_ACTIVE - 1))
                        && (32'(vcount_in) == 32'(V_ACTIVE - 1));

`ifdef SCALE_MIRROR_EN
    assign w_col_eff = ADDR_W'(FB_WIDTH - 1) - ADDR_W'(w_col);
`else
    assign w_col_eff = ADDR_W'(w_col);
`endif

    // Full-width multiply-add: an in-region row*FB_WIDTH+col is always below
    // FB_WIDTH*FB_HEIGHT, which ADDR_W is sized to hold, so nothing is lost.
    assign w_addr = w_in_region ? (ADDR_W'(w_row) * ADDR_W'(FB_WIDTH) + w_col_eff)
                                : '0;

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            r_addr      <= '0;
            r_valid     <= 1'b0;
            r_hsync     <= 1'b0;
            r_vsync     <= 1'b0;
            r_active    <= 1'b0;
            r_last      <= 1'b0;
            r_dl_valid  <= '0;
            r_dl_hsync  <= '0;
            r_dl_vsync  <= '0;
            r_dl_active <= '0;
            r_dl_last   <= '0;
        end else begin
            r_addr      <= w_addr;
            r_valid     <= w_in_region;
            r_hsync     <= hsync_in;
            r_vsync     <= vsync_in;
            r_active    <= active_draw_in;
            r_last      <= w_last_pos;

            r_dl_valid[0]  <= r_valid;
            r_dl_hsync[0]  <= r_hsync;
            r_dl_vsync[0]  <= r_vsync;
            r_dl_active[0] <= r_active;
            r_dl_last[0]   <= r_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_dl_valid[i]  <= r_dl_valid[i-1];
                r_dl_hsync[i]  <= r_dl_hsync[i-1];
                r_dl_vsync[i]  <= r_dl_vsync[i-1];
                r_dl_active[i] <= r_dl_active[i-1];
                r_dl_last[i]   <= r_dl_last[i-1];
            end
        end
    end

    assign bram_addr_out   = r_addr;
    assign hsync_out       = r_dl_hsync[READ_LATENCY-1];
    assign vsync_out       = r_dl_vsync[READ_LATENCY-1];
    assign active_draw_out = r_dl_active[READ_LATENCY-1];
    assign frame_done_out  = r_dl_last[READ_LATENCY-1];

    // The BRAM output register is the pipeline's last stage; only the mux
    // that blacks out invalid positions sits after it.
    assign scaled_pixel_out = r_dl_valid[READ_LATENCY-1] ? bram_data_in : 8'h00;

endmodule

// File: tb/tb_scaled_pixel_fetch.sv
module tb_scaled_pixel_fetch;

    localparam int HN = 8192;

`ifdef SCALE_MIRROR_EN
    localparam int LIT_A0   = 958;    // h=5,v=9 mirrored: 2*320 + (319-1)
    localparam int LIT_EDGE = 57280;  // h=1279,v=719 mirrored: 179*320 + 0
    localparam int LIT_ORG  = 319;    // h=0,v=0 mirrored
`else
    localparam int LIT_A0   = 641;
    localparam int LIT_EDGE = 57599;
    localparam int LIT_ORG  = 0;
`endif

    typedef struct {
        int h;
        int v;
        bit hs;
        bit vs;
        bit ad;
    } in_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        hs, vs, ad;

    logic [15:0] addr_a, addr_b;
    logic [7:0]  data_a, data_b, pix_a, pix_b;
    logic        hso_a, vso_a, ado_a, done_a;
    logic        hso_b, vso_b, ado_b, done_b;

    logic [7:0]  mem [0:65535];
    logic [7:0]  a_q1, a_q2, b_q1;

    in_t hist [0:HN-1];
    int  cyc = 0;
    int  rel_cyc;
    bit  rel_pending = 1'b0;
    bit  chk_en = 1'b0;
    int  checks = 0;
    int  errors = 0;
    int  done_cnt_a = 0;
    int  done_cnt_b = 0;

    always #5 clk = ~clk;

    scaled_pixel_fetch dut_a (
        .clk_pixel_in    (clk),
        .rst_in          (rst),
        .hcount_in       (hc),
        .vcount_in       (vc),
        .hsync_in        (hs),
        .vsync_in        (vs),
        .active_draw_in  (ad),
        .bram_addr_out   (addr_a),
        .bram_data_in    (data_a),
        .scaled_pixel_out(pix_a),
        .hsync_out       (hso_a),
        .vsync_out       (vso_a),
        .active_draw_out (ado_a),
        .frame_done_out  (done_a)
    );

    scaled_pixel_fetch #(.READ_LATENCY(1)) dut_b (
        .clk_pixel_in    (clk),
        .rst_in          (rst),
        .hcount_in       (hc),
        .vcount_in       (vc),
        .hsync_in        (hs),
        .vsync_in        (vs),
        .active_draw_in  (ad),
        .bram_addr_out   (addr_b),
        .bram_data_in    (data_b),
        .scaled_pixel_out(pix_b),
        .hsync_out       (hso_b),
        .vsync_out       (vso_b),
        .active_draw_out (ado_b),
        .frame_done_out  (done_b)
    );

    // Framebuffer memories: two-cycle and one-cycle read latency
    always @(posedge clk) begin
        a_q1 <= mem[addr_a];
        a_q2 <= a_q1;
        b_q1 <= mem[addr_b];
    end
    assign data_a = a_q2;
    assign data_b = b_q1;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: framebuffer coordinate from the raster position
    function automatic bit exp_valid(in_t p);
        return p.ad && (p.h / 4 < 320) && (p.v / 4 < 180);
    endfunction

    function automatic int exp_addr(in_t p);
        int col;
        int row;
        col = p.h / 4;
        row = p.v / 4;
        if (!exp_valid(p)) return 0;
`ifdef SCALE_MIRROR_EN
        col = 319 - col;
`endif
        return row * 320 + col;
    endfunction

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // An output in cycle c reflects the input of cycle c-1-lat, provided that
    // input was applied after the most recent reset release.
    task automatic check_inst(string tag, int lat, int addr, int pix,
                              int hso, int vso, int ado, int done);
        int  ea, ep, eh, ev, ead, ed, n;
        in_t p;
        ea = 0; ep = 0; eh = 0; ev = 0; ead = 0; ed = 0;
        if (!rst) begin
            n = cyc - 1;
            if (n >= rel_cyc) ea = exp_addr(hist[n % HN]);
            n = cyc - lat - 1;
            if (n >= rel_cyc) begin
                p = hist[n % HN];
                if (exp_valid(p)) ep = int'(mem[exp_addr(p)]);
                eh  = int'(p.hs);
                ev  = int'(p.vs);
                ead = int'(p.ad);
                ed  = int'(p.h == 1279 && p.v == 719);
            end
        end
        chk({tag, ".addr"},  addr, ea);
        chk({tag, ".pixel"}, pix,  ep);
        chk({tag, ".hsync"}, hso,  eh);
        chk({tag, ".vsync"}, vso,  ev);
        chk({tag, ".active"}, ado, ead);
        chk({tag, ".done"},  done, ed);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst("A", 2, int'(addr_a), int'(pix_a), int'(hso_a),
                       int'(vso_a), int'(ado_a), int'(done_a));
            check_inst("B", 1, int'(addr_b), int'(pix_b), int'(hso_b),
                       int'(vso_b), int'(ado_b), int'(done_b));
            done_cnt_a += int'(done_a);
            done_cnt_b += int'(done_b);
        end
    end

    task automatic drive(int h, int v, bit s_h, bit s_v, bit a);
        @(posedge clk);
        #1;
        hc = 11'(h);
        vc = 10'(v);
        hs = s_h;
        vs = s_v;
        ad = a;
        if (rel_pending) begin
            rst = 1'b0;
            rel_cyc = cyc;
            rel_pending = 1'b0;
        end
        hist[cyc % HN] = '{h, v, s_h, s_v, a};
    endtask

    task automatic zero_outputs(string tag);
        chk({tag, ".A.addr"},  int'(addr_a), 0);
        chk({tag, ".A.pixel"}, int'(pix_a),  0);
        chk({tag, ".A.hsync"}, int'(hso_a),  0);
        chk({tag, ".A.vsync"}, int'(vso_a),  0);
        chk({tag, ".A.active"}, int'(ado_a), 0);
        chk({tag, ".A.done"},  int'(done_a), 0);
        chk({tag, ".B.addr"},  int'(addr_b), 0);
        chk({tag, ".B.pixel"}, int'(pix_b),  0);
        chk({tag, ".B.done"},  int'(done_b), 0);
    endtask

    task automatic sync_pulse(int sel);
        drive(40, 5, sel == 0, sel == 1, sel == 2);
        for (int k = 1; k <= 4; k++) begin
            drive(40 + k, 5, 1'b0, 1'b0, 1'b0);
            #2;
            case (sel)
                0: begin
                    chk("hsync_align.A", int'(hso_a), int'(k == 3));
                    chk("hsync_align.B", int'(hso_b), int'(k == 2));
                end
                1: begin
                    chk("vsync_align.A", int'(vso_a), int'(k == 3));
                    chk("vsync_align.B", int'(vso_b), int'(k == 2));
                end
                default: begin
                    chk("active_align.A", int'(ado_a), int'(k == 3));
                    chk("active_align.B", int'(ado_b), int'(k == 2));
                end
            endcase
        end
    endtask

    initial begin
        in_t probe;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[LIT_A0] = 8'hC2;
        for (int i = 0; i < HN; i++) hist[i] = '{0, 0, 1'b0, 1'b0, 1'b0};
        hc = '0; vc = '0; hs = 1'b0; vs = 1'b0; ad = 1'b0;
        rst = 1'b0;
        rel_cyc = 1 << 30;
        #1 rst = 1'b1;
        chk_en = 1'b1;

        // Held in reset
        repeat (2) @(posedge clk);
        #2 zero_outputs("reset");

        // Release, then walk line 9 through the h=5 probe
        rel_pending = 1'b1;
        for (int h = 0; h <= 5; h++) drive(h, 9, 1'b0, 1'b0, 1'b1);
        drive(6, 9, 1'b0, 1'b0, 1'b1);
        #2 chk("addr_h5v9", int'(addr_a), LIT_A0);
        drive(7, 9, 1'b0, 1'b0, 1'b1);
        #2 chk("pixel_h5v9.B", int'(pix_b), 8'hC2);
        drive(8, 9, 1'b0, 1'b0, 1'b1);
        #2 chk("pixel_h5v9.A", int'(pix_a), 8'hC2);
        for (int h = 9; h < 24; h++) drive(h, 9, 1'b0, 1'b0, 1'b1);

        // Region edge and the first frame end
        for (int h = 1270; h <= 1278; h++) drive(h, 719, 1'b0, 1'b0, 1'b1);
        drive(1279, 719, 1'b0, 1'b0, 1'b1);
        drive(1280, 719, 1'b0, 1'b0, 1'b0);
        #2 chk("addr_edge", int'(addr_a), LIT_EDGE);
        drive(1281, 719, 1'b0, 1'b0, 1'b0);
        #2 chk("addr_h1280", int'(addr_a), 0);
        drive(1282, 719, 1'b0, 1'b0, 1'b0);
        #2 chk("pixel_edge", int'(pix_a), int'(mem[LIT_EDGE]));
        chk("frame_done_edge", int'(done_a), 1);
        drive(1283, 719, 1'b0, 1'b0, 1'b0);
        #2 chk("pixel_h1280", int'(pix_a), 0);
        chk("frame_done_single", int'(done_a), 0);
        for (int h = 1284; h < 1296; h++) drive(h, 719, 1'b1, 1'b0, 1'b0);

        // Wrap to line 0
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        drive(1, 0, 1'b0, 1'b1, 1'b1);
        #2 chk("addr_origin", int'(addr_a), LIT_ORG);
        for (int h = 2; h < 12; h++) drive(h, 0, 1'b0, 1'b0, 1'b1);

        // Sync / active alignment
        sync_pulse(0);
        sync_pulse(1);
        sync_pulse(2);

        // Active but outside the framebuffer
        drive(1300, 10, 1'b0, 1'b0, 1'b1);
        drive(2047, 10, 1'b0, 1'b0, 1'b1);
        #2 chk("addr_col_oor", int'(addr_a), 0);
        drive(0, 720, 1'b0, 1'b0, 1'b1);
        drive(100, 1023, 1'b0, 1'b0, 1'b1);
        #2 chk("addr_row_oor", int'(addr_a), 0);
        drive(16, 800, 1'b0, 1'b0, 1'b1);

        // Frame end while blanked: pulse still expected, pixel black
        drive(1278, 719, 1'b0, 1'b0, 1'b1);
        drive(1279, 719, 1'b0, 1'b0, 1'b0);
        drive(1280, 719, 1'b0, 1'b0, 1'b0);
        drive(1281, 719, 1'b0, 1'b0, 1'b0);
        drive(1282, 719, 1'b0, 1'b0, 1'b0);
        #2 chk("frame_done_blanked", int'(done_a), 1);
        chk("pixel_blanked", int'(pix_a), 0);
        for (int h = 1283; h < 1290; h++) drive(h, 719, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame at h=600, v=300
        for (int h = 590; h <= 600; h++) drive(h, 300, 1'b0, 1'b0, 1'b1);
        #1 rst = 1'b1;
        #1 zero_outputs("midreset");
        drive(601, 300, 1'b0, 1'b0, 1'b1);
        drive(602, 300, 1'b0, 1'b0, 1'b1);
        rel_pending = 1'b1;
        drive(603, 300, 1'b0, 1'b0, 1'b1);
        for (int h = 604; h <= 606; h++) drive(h, 300, 1'b0, 1'b0, 1'b1);
        probe = '{603, 300, 1'b0, 1'b0, 1'b1};
        #2 chk("pixel_after_reset", int'(pix_a), int'(mem[exp_addr(probe)]));
        for (int h = 607; h < 630; h++) drive(h, 300, 1'b0, 1'b0, 1'b1);

        // Reset right after the last position: its pulse must not appear
        drive(1279, 719, 1'b0, 1'b0, 1'b1);
        drive(1280, 719, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        drive(1281, 719, 1'b0, 1'b0, 1'b0);
        drive(1282, 719, 1'b0, 1'b0, 1'b0);
        rel_pending = 1'b1;
        for (int h = 0; h < 8; h++) drive(h, 0, 1'b0, 1'b0, 1'b1);

        // Short sequential raster chunk, then random positions
        for (int v = 100; v < 104; v++)
            for (int h = 0; h < 40; h++) drive(h, v, h < 2, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++)
            drive(int'($urandom_range(1400, 0)), int'($urandom_range(718, 0)),
                  1'($urandom), 1'($urandom), 1'($urandom));
        repeat (6) drive(0, 0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        chk("frame_done_count.A", done_cnt_a, 2);
        chk("frame_done_count.B", done_cnt_b, 2);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scaled_pixel_fetch.md
SCALED_PIXEL_FETCH -- requirements
Module: scaled_pixel_fetch

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280: active display width in pixels.
REQ-002 SHALL have parameter V_ACTIVE, default 720: active display height in lines.
REQ-003 SHALL have parameter SCALE_SHIFT, default 2: log2 of the upscale factor (4x).
REQ-004 SHALL have parameter FB_WIDTH, default 320: framebuffer columns.
REQ-005 SHALL have parameter FB_HEIGHT, default 180: framebuffer rows.
REQ-006 SHALL have parameter ADDR_W, default 16: BRAM address width.
REQ-007 SHALL have parameter READ_LATENCY, default 2: BRAM read latency in cycles (legal range 1-4).
REQ-008 SHALL have port clk_pixel_in, input, 1 bit: pixel clock; one clock, all logic on its rising edge.
REQ-009 SHALL have port rst_in, input, 1 bit: reset; asynchronous, active-high.
REQ-010 SHALL have ports hcount_in (11 bits) and vcount_in (10 bits), inputs: raster position from the timing generator.
REQ-011 SHALL have ports hsync_in, vsync_in and active_draw_in, inputs, 1 bit each: timing-generator syncs and active-video flag.
REQ-012 SHALL have port bram_addr_out, output, ADDR_W bits: framebuffer read address.
REQ-013 SHALL have port bram_data_in, input, 8 bits: framebuffer read data.
REQ-014 SHALL have port scaled_pixel_out, output, 8 bits: pixel to the colour mux; [7:6] type, [5:0] payload.
REQ-015 SHALL have ports hsync_out, vsync_out and active_draw_out, outputs, 1 bit each: syncs and active flag, aligned with scaled_pixel_out.
REQ-016 SHALL have port frame_done_out, output, 1 bit: single-cycle end-of-frame pulse.

Function
REQ-017 Address rule: col = hcount_in>>SCALE_SHIFT, row = vcount_in>>SCALE_SHIFT, addr = row*FB_WIDTH + col.
REQ-018 Arithmetic SHALL be exact with no truncation for any in-region position.
REQ-019 Out-of-region condition: col >= FB_WIDTH, row >= FB_HEIGHT, or active_draw_in = 0.
REQ-020 For an out-of-region position, bram_addr_out SHALL be 0 and the position SHALL be tagged invalid.
REQ-021 Stage 0 SHALL register the address and valid tag one cycle after the inputs.
REQ-022 A delay line SHALL carry the valid tag, hsync, vsync and active_draw for READ_LATENCY further cycles.
REQ-023 Total latency from inputs to all outputs SHALL be exactly 1+READ_LATENCY cycles (3 at default), identical for data and syncs.
REQ-024 If the tag is valid, scaled_pixel_out SHALL be bram_data_in sampled in that cycle.
REQ-025 If the tag is invalid, scaled_pixel_out SHALL be 8'h00 (type 00, black).
REQ-026 frame_done_out SHALL pulse high for exactly one cycle, aligned with the output of position (H_ACTIVE-1, V_ACTIVE-1).
REQ-027 frame_done_out SHALL pulse even when that position is out-of-region.
REQ-028 Counts outside the active area SHALL pass through without error; syncs SHALL be delayed unchanged.
REQ-029 Behaviour SHALL be combinational-free on outputs: every output is driven from a register, except scaled_pixel_out, which is registered or muxed from bram_data_in per REQ-024.
REQ-030 Row wrap: when vcount_in returns to 0, addressing SHALL restart at row 0 with no stale row state.

Reset
REQ-031 When rst_in is asserted, all pipeline registers SHALL clear immediately, without waiting for a clock edge.
REQ-032 During reset: bram_addr_out = 0, scaled_pixel_out = 8'h00, hsync_out = 0, vsync_out = 0, active_draw_out = 0, frame_done_out = 0.
REQ-033 After reset release, outputs SHALL reflect the inputs after 1+READ_LATENCY cycles.
REQ-034 After reset release, outputs SHALL be black and invalid until pipeline data emerges.
REQ-035 A reset mid-frame SHALL NOT produce a frame_done_out pulse.

Configuration
REQ-036 Macro SCALE_MIRROR_EN SHALL control horizontal mirroring.
REQ-037 When SCALE_MIRROR_EN is defined, col SHALL be replaced by FB_WIDTH-1-col for in-region pixels (selfie-view mirror).
REQ-038 When SCALE_MIRROR_EN is undefined, addressing SHALL follow REQ-017 unchanged.
REQ-039 Latency, reset behaviour and all other behaviour SHALL be identical in both builds.

Verification
REQ-040 Address check: h=5, v=9, active=1 -> bram_addr_out = 2*320+1 = 641 one cycle later; bram_data_in = 8'hC2 -> scaled_pixel_out = 8'hC2 three cycles after input.
REQ-041 Region edge: h=1279, v=719 -> addr = 179*320+319 = 57599; h=1280 (active=0) -> addr 0 and pixel 8'h00.
REQ-042 Sync alignment: single-cycle hsync_in pulse -> hsync_out pulse exactly 3 cycles later; same for vsync and active_draw with READ_LATENCY=2 and READ_LATENCY=1 (2 cycles).
REQ-043 Frame end: full 1280x720 raster -> exactly one frame_done_out pulse per frame, coincident with the output of the last active pixel.
REQ-044 Reset mid-frame: assert rst_in asynchronously at h=600, v=300 -> all outputs 0 before the next edge; no frame_done_out pulse; correct data 3 cycles after release.
REQ-045 Mirror build: SCALE_MIRROR_EN defined, h=0, v=0 -> addr 319; undefined -> addr 0.
